// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault codes,
// NOP encoding and the default reset PC.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } ifu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } fault_cause_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// 8-bit up-counter measuring how long a fetch request has been outstanding;
// tc flags the last cycle an ack may still be accepted.
module ifu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= 8'd0;
    else if (clr)
      count <= 8'd0;
    else if (en)
      count <= count + 8'd1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one fetch per instruction, latches the returned
// word, presents it for one execute cycle and traps on misaligned PC or ack timeout.
//
//   state   | meaning
//   S_REQ   | request outstanding at pc, waiting for imem_ack
//   S_EXEC  | instr valid for one cycle, nextpc sampled at its end
//   S_FAULT | terminal fault, held until reset
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nextpc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        waitt,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  ifu_state_t   state, state_nxt;
  fault_cause_t cause_q, cause_nxt;
  logic         req_armed;
  logic         ld_pc, ld_instr, ld_cause;
  logic         ctr_tc;

  // Requests only start on the first edge after reset release, so an ack
  // landing in that first cycle belongs to the abandoned pre-reset fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      req_armed <= 1'b0;
    else
      req_armed <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_REQ;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ld_pc       = 1'b0;
    ld_instr    = 1'b0;
    ld_cause    = 1'b0;
    cause_nxt   = CAUSE_NONE;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    waitt       = 1'b1;
    case (state)
      S_REQ: begin
        if (req_armed) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ld_instr  = 1'b1;
            state_nxt = S_EXEC;
          end else if (ctr_tc) begin
            ld_cause  = 1'b1;
            cause_nxt = CAUSE_TIMEOUT;
            state_nxt = S_FAULT;
          end
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        waitt       = 1'b0;
        if (is_word_aligned(nextpc)) begin
          ld_pc     = 1'b1;
          state_nxt = S_REQ;
        end else begin
          ld_cause  = 1'b1;
          cause_nxt = CAUSE_MISALIGN;
          state_nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      cause_q <= CAUSE_NONE;
    end else begin
      if (ld_pc)
        pc <= nextpc;
      if (ld_instr)
        instr <= imem_rdata;
      if (ld_cause)
        cause_q <= cause_nxt;
    end
  end

  // Counter runs only while a request is on the bus; an accepted ack clears it.
  ifu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (!imem_req || imem_ack),
    .en   (imem_req && !imem_ack),
    .tc   (ctr_tc)
  );

  assign imem_addr   = pc;
  assign fetch_fault = (state == S_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with the default timeout
// and a second with TIMEOUT_CYCLES=4 for the timeout boundary.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, reset4;
  logic [31:0] nextpc, nextpc4;
  logic        imem_ack, imem_ack4;
  logic [31:0] imem_rdata, imem_rdata4;

  logic [31:0] pc, imem_addr, instr;
  logic        imem_req, instr_valid, waitt, fetch_fault;
  logic [1:0]  fault_cause;

  logic [31:0] pc4, imem_addr4, instr4;
  logic        imem_req4, instr_valid4, waitt4, fetch_fault4;
  logic [1:0]  fault_cause4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .nextpc(nextpc), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr(instr), .instr_valid(instr_valid), .waitt(waitt),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .reset(reset4), .nextpc(nextpc4), .imem_ack(imem_ack4),
    .imem_rdata(imem_rdata4), .pc(pc4), .imem_req(imem_req4), .imem_addr(imem_addr4),
    .instr(instr4), .instr_valid(instr_valid4), .waitt(waitt4),
    .fetch_fault(fetch_fault4), .fault_cause(fault_cause4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reset4 = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; nextpc = 32'h0;
    imem_ack4 = 1'b0; imem_rdata4 = 32'h0; nextpc4 = 32'h8000_0004;
    #1 reset = 1'b1; reset4 = 1'b1;
    #2;
    check("rst_pc",      pc,          32'h8000_0000);
    check("rst_instr",   instr,       32'h0000_0013);
    check("rst_req",     imem_req,    0);
    check("rst_valid",   instr_valid, 0);
    check("rst_waitt",   waitt,       1);
    check("rst_fault",   fetch_fault, 0);
    check("rst_cause",   fault_cause, 0);

    // release reset with a stale ack in the first cycle
    tick;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
    #1 check("rel_req0", imem_req, 0);
    tick;
    imem_ack = 1'b0;
    check("first_req",    imem_req,    1);
    check("first_addr",   imem_addr,   32'h8000_0000);
    check("first_valid",  instr_valid, 0);
    check("stale_ack",    instr,       32'h0000_0013);

    // single-cycle ack, sequential run
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; nextpc = 32'h8000_0004;
    tick;
    imem_ack = 1'b0;
    check("ex1_valid", instr_valid, 1);
    check("ex1_waitt", waitt,       0);
    check("ex1_req",   imem_req,    0);
    check("ex1_instr", instr,       32'h0050_0093);
    check("ex1_pc",    pc,          32'h8000_0000);
    tick;
    check("seq_pc1",    pc,          32'h8000_0004);
    check("seq_addr1",  imem_addr,   32'h8000_0004);
    check("seq_valid1", instr_valid, 0);
    check("seq_waitt1", waitt,       1);
    imem_ack = 1'b1; imem_rdata = 32'h0010_0113; nextpc = 32'h8000_0008;
    tick;
    check("ex2_instr", instr, 32'h0010_0113);
    // ack during execute must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    check("seq_pc2",      pc,    32'h8000_0008);
    check("exec_ack_ign", instr, 32'h0010_0113);
    check("seq_req2",     imem_req, 1);

    // ack latency 5 with nextpc churning during the stall
    for (int i = 0; i < 5; i++) begin
      check("stall_waitt", waitt,    1);
      check("stall_req",   imem_req, 1);
      nextpc = 32'h1234_5671 + i;
      imem_ack = (i == 4);
      imem_rdata = 32'h00A0_0113;
      tick;
    end
    imem_ack = 1'b0;
    nextpc = 32'h8000_0100;
    check("lat5_valid", instr_valid, 1);
    check("lat5_instr", instr,       32'h00A0_0113);
    check("lat5_pc",    pc,          32'h8000_0008);
    tick;
    check("lat5_addr", imem_addr, 32'h8000_0100);

    // wrap from 0xFFFFFFFC to 0
    imem_ack = 1'b1; nextpc = 32'hFFFF_FFFC;
    tick; tick;
    check("wrap_hi", pc, 32'hFFFF_FFFC);
    nextpc = 32'h0000_0000;
    tick; tick;
    check("wrap_zero", pc, 32'h0000_0000);

    // misaligned nextpc traps
    nextpc = 32'h8000_0102; imem_rdata = 32'h0000_0001;
    tick;
    imem_ack = 1'b0;
    tick;
    check("mis_fault", fetch_fault, 1);
    check("mis_cause", fault_cause, 2'b01);
    check("mis_pc",    pc,          32'h0000_0000);
    check("mis_req",   imem_req,    0);
    check("mis_waitt", waitt,       1);
    check("mis_valid", instr_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000; nextpc = 32'h0000_0040;
    tick; tick; tick;
    imem_ack = 1'b0;
    check("flt_hold",  fetch_fault, 1);
    check("flt_instr", instr,       32'h0000_0001);
    check("flt_pc",    pc,          32'h0000_0000);
    check("flt_req",   imem_req,    0);

    // asynchronous reset clears the fault without a clock edge
    reset = 1'b1;
    #1;
    check("arst_fault", fetch_fault, 0);
    check("arst_pc",    pc,          32'h8000_0000);
    check("arst_cause", fault_cause, 0);
    check("arst_instr", instr,       32'h0000_0013);
    tick;
    reset = 1'b0;
    tick;
    check("rearm_req", imem_req, 1);

    // reset mid-fetch, ack arrives right after release
    reset = 1'b1;
    tick;
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    tick;
    imem_ack = 1'b0;
    check("midrst_instr", instr,       32'h0000_0013);
    check("midrst_pc",    pc,          32'h8000_0000);
    check("midrst_req",   imem_req,    1);
    check("midrst_valid", instr_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'h0010_0073; nextpc = 32'h8000_0004;
    tick;
    imem_ack = 1'b0;
    check("midrst_exec", instr_valid, 1);
    check("midrst_new",  instr,       32'h0010_0073);

    // TIMEOUT_CYCLES=4: no ack -> fault after four request cycles
    reset4 = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("t4_req",   imem_req4,    1);
      check("t4_nofl",  fetch_fault4, 0);
      tick;
    end
    check("t4_fault", fetch_fault4, 1);
    check("t4_cause", fault_cause4, 2'b10);
    check("t4_req0",  imem_req4,    0);
    check("t4_waitt", waitt4,       1);
    check("t4_pc",    pc4,          32'h8000_0000);

    // ack in the fourth cycle wins over the timeout
    reset4 = 1'b1;
    tick;
    reset4 = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      imem_ack4 = (i == 3);
      imem_rdata4 = 32'h0020_0113;
      tick;
    end
    imem_ack4 = 1'b0;
    check("t4_ack_valid", instr_valid4, 1);
    check("t4_ack_fault", fetch_fault4, 0);
    check("t4_ack_instr", instr4,       32'h0020_0113);
    tick;
    check("t4_next_addr", imem_addr4, 32'h8000_0004);
    check("t4_next_req",  imem_req4,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h80000000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 255, max cycles waiting for imem_ack before fault; range 1..255.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 nextpc  in  32  next PC from PC selector; stable before the rising edge that ends S_EXEC.
REQ-006 imem_ack  in  1  instruction memory response valid, one-cycle pulse.
REQ-007 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 pc  out  32  current architectural PC.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 imem_addr  out  32  fetch address, equals pc while imem_req=1.
REQ-011 instr  out  32  latched instruction word.
REQ-012 instr_valid  out  1  instr executable this cycle.
REQ-013 waitt  out  1  stall to PC selector; 1 = hold nextpc.
REQ-014 fetch_fault  out  1  sticky fault flag.
REQ-015 fault_cause  out  2  00 none, 01 misaligned nextpc, 10 ack timeout.

Function
REQ-016 FSM states SHALL be S_REQ, S_EXEC, S_FAULT.
REQ-017 S_REQ: imem_req=1, imem_addr=pc, waitt=1, instr_valid=0; timeout counter increments each cycle.
REQ-018 S_REQ with imem_ack=1: instr<=imem_rdata, counter<=0, next state S_EXEC; imem_req deasserts the following cycle.
REQ-019 S_REQ with imem_ack=0 and counter=TIMEOUT_CYCLES-1: next state S_FAULT, fault_cause<=10.
REQ-020 Ack latency SHALL be 1..TIMEOUT_CYCLES cycles after the first imem_req cycle; an ack in the timeout cycle itself is accepted (ack wins).
REQ-021 S_EXEC lasts exactly one cycle: instr_valid=1, waitt=0, imem_req=0.
REQ-022 End of S_EXEC with nextpc[1:0]==00: pc<=nextpc, next state S_REQ.
REQ-023 End of S_EXEC with nextpc[1:0]!=00: pc unchanged, next state S_FAULT, fault_cause<=01.
REQ-024 S_FAULT is terminal until reset: waitt=1, imem_req=0, instr_valid=0, fetch_fault=1, pc/instr/fault_cause held.
REQ-025 imem_ack outside S_REQ SHALL be ignored; no state or output change.
REQ-026 Steady throughput with 1-cycle ack: one instruction per 2 cycles (S_REQ, S_EXEC).
REQ-027 pc is 32-bit with no carry-out; 0xFFFFFFFC to 0x00000000 via nextpc is legal.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state S_REQ, pc=RESET_PC, instr=32'h00000013 (NOP), counter=0, fetch_fault=0, fault_cause=00.
REQ-029 While reset=1: imem_req=0, instr_valid=0, waitt=1.
REQ-030 Reset mid-fetch abandons the request; any ack arriving in the first cycle after deassertion SHALL be ignored (counter cleared, fresh request issued).
REQ-031 First request SHALL issue on the first rising edge after reset deasserts, imem_addr=RESET_PC.

Structure
REQ-032 Shared package ifu_pkg: state enum (S_REQ, S_EXEC, S_FAULT), fault_cause codes, NOP encoding, default RESET_PC.
REQ-033 One sub-module ifu_timeout_ctr: 8-bit counter with clear, enable and terminal-count output at TIMEOUT_CYCLES-1.
REQ-034 FSM, PC register and instr latch reside in instr_fetch_unit; no memory inside the block.

Verification
REQ-035 Reset release, ack 1 cycle after req, rdata=0x00500093 -> imem_addr=0x80000000, instr=0x00500093, instr_valid pulses 1 cycle, waitt=0 in that cycle only.
REQ-036 Sequential run, nextpc=pc+4, ack latency 1 -> pc sequence 0x80000000, 0x80000004, 0x80000008 at 2-cycle spacing.
REQ-037 Ack latency 5 with nextpc=0x80000100 -> waitt=1 for 5 cycles, then fetch at 0x80000100; stale nextpc changes during stall have no effect.
REQ-038 nextpc=0x80000102 at end of S_EXEC -> fetch_fault=1, fault_cause=01, pc held, imem_req=0 until reset.
REQ-039 TIMEOUT_CYCLES=4, no ack -> S_FAULT after 4 req cycles, fault_cause=10; ack on 4th cycle instead -> normal S_EXEC.
REQ-040 reset asserted during S_REQ, ack arrives next cycle -> ack ignored, pc=0x80000000, new request after deassertion.
